hazard_scoreboard: RTL and testbench

//   Issue-stage RAW/WAW interlock sitting directly downstream of the register

---
 rtl/hazard_scoreboard.sv | 161 ++++++++++++++++
 tb/tb_hazard_scoreboard.sv | 394 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: issue-stage RAW/WAW interlock with
// per-register pending-writer counters for GPRs and EFLAGS.
module hazard_scoreboard #(
  parameter int NUM_GPR = 16,
  parameter int IDX_W   = 4,
  parameter int CNT_W   = 2,
  parameter int STAT_W  = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               issue_valid,
  output logic               issue_ready,
  input  logic               u_from_gd,
  input  logic               u_to_gd,
  input  logic               u_from_gs,
  input  logic               u_from_gt,
  input  logic               u_from_ef,
  input  logic               u_to_ef,
  input  logic [IDX_W-1:0]   u_d,
  input  logic [IDX_W-1:0]   u_s,
  input  logic [IDX_W-1:0]   u_t,
  input  logic               wb_gd_valid,
  input  logic [IDX_W-1:0]   wb_gd_idx,
  input  logic               wb_ef_valid,
  output logic [NUM_GPR-1:0] gpr_busy,
  output logic               ef_busy,
  output logic               sb_error,
  output logic [STAT_W-1:0]  stall_cycles
);

  localparam logic [CNT_W-1:0] CMAX = '1;
  localparam logic [CNT_W-1:0] CONE = CNT_W'(1);

  logic [CNT_W-1:0]   r_gcnt [NUM_GPR];
  logic [CNT_W-1:0]   r_ecnt;
  logic               r_sb_error;
  logic [STAT_W-1:0]  r_stall;

  logic [CNT_W-1:0]   w_gnext [NUM_GPR];
  logic [CNT_W-1:0]   w_enext;
  logic [NUM_GPR-1:0] w_busy;
  logic [NUM_GPR-1:0] w_ginc;
  logic [NUM_GPR-1:0] w_gdec;
  logic               w_ebusy;
  logic               w_raw;
  logic               w_sat;
  logic               w_ready;
  logic               w_fire;
  logic               w_einc;
  logic               w_edec;
  logic               w_gerr;
  logic               w_eerr;

  // Busy flags come from registered counts only: no writeback bypass.
  always_comb begin
    w_busy = '0;
    for (int r = 0; r < NUM_GPR; r++) begin
      w_busy[r] = |r_gcnt[r];
    end
    w_ebusy = |r_ecnt;
  end

  // Hazard detect, counter saturation guard and issue handshake.
  always_comb begin
    w_raw = (u_from_gs & w_busy[u_s])
          | (u_from_gt & w_busy[u_t])
          | (u_from_gd & w_busy[u_d])
          | (u_from_ef & w_ebusy);
    w_sat = (u_to_gd & (r_gcnt[u_d] == CMAX))
          | (u_to_ef & (r_ecnt == CMAX));
    w_ready = ~w_raw & ~w_sat & ~flush;
    w_fire  = issue_valid & w_ready;
  end

  // Per-register increment (issue) and decrement (writeback) strobes.
  always_comb begin
    w_ginc = '0;
    w_gdec = '0;
    for (int r = 0; r < NUM_GPR; r++) begin
      w_ginc[r] = w_fire & u_to_gd & (u_d == IDX_W'(r));
      w_gdec[r] = wb_gd_valid & (wb_gd_idx == IDX_W'(r));
    end
    w_einc = w_fire & u_to_ef;
    w_edec = wb_ef_valid;
  end

  // Next GPR counts; a decrement at zero holds and flags an error.
  always_comb begin
    w_gerr = 1'b0;
    for (int r = 0; r < NUM_GPR; r++) begin
      w_gnext[r] = r_gcnt[r];
      if (w_ginc[r] & ~w_gdec[r]) begin
        w_gnext[r] = r_gcnt[r] + CONE;
      end else if (w_gdec[r] & ~w_ginc[r]) begin
        if (r_gcnt[r] == '0) begin
          w_gerr = 1'b1;
        end else begin
          w_gnext[r] = r_gcnt[r] - CONE;
        end
      end
    end
  end

  // Next EFLAGS count, same rules as the GPR counters.
  always_comb begin
    w_eerr  = 1'b0;
    w_enext = r_ecnt;
    if (w_einc & ~w_edec) begin
      w_enext = r_ecnt + CONE;
    end else if (w_edec & ~w_einc) begin
      if (r_ecnt == '0) begin
        w_eerr = 1'b1;
      end else begin
        w_enext = r_ecnt - CONE;
      end
    end
  end

  // Counter state: reset beats flush; flush drops all pending writes.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NUM_GPR; r++) begin
        r_gcnt[r] <= '0;
      end
      r_ecnt <= '0;
    end else if (flush) begin
      for (int r = 0; r < NUM_GPR; r++) begin
        r_gcnt[r] <= '0;
      end
      r_ecnt <= '0;
    end else begin
      for (int r = 0; r < NUM_GPR; r++) begin
        r_gcnt[r] <= w_gnext[r];
      end
      r_ecnt <= w_enext;
    end
  end

  // Sticky error and saturating stall statistics, kept across flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sb_error <= 1'b0;
      r_stall    <= '0;
    end else begin
      if (~flush & (w_gerr | w_eerr)) begin
        r_sb_error <= 1'b1;
      end
      if (issue_valid & ~w_ready & ~(&r_stall)) begin
        r_stall <= r_stall + STAT_W'(1);
      end
    end
  end

  assign issue_ready  = w_ready;
  assign gpr_busy     = w_busy;
  assign ef_busy      = w_ebusy;
  assign sb_error     = r_sb_error;
  assign stall_cycles = r_stall;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: scenario tasks for the issue interlock,
// expectations queued as stimulus is driven and popped on sampling.
module tb_hazard_scoreboard;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        issue_valid;
  logic        issue_ready;
  logic        u_from_gd;
  logic        u_to_gd;
  logic        u_from_gs;
  logic        u_from_gt;
  logic        u_from_ef;
  logic        u_to_ef;
  logic [3:0]  u_d;
  logic [3:0]  u_s;
  logic [3:0]  u_t;
  logic        wb_gd_valid;
  logic [3:0]  wb_gd_idx;
  logic        wb_ef_valid;
  logic [15:0] gpr_busy;
  logic        ef_busy;
  logic        sb_error;
  logic [31:0] stall_cycles;

  int          checks;
  int          failures;
  int          exp_stall;
  logic [31:0] sb [$];
  logic [31:0] ex;

  hazard_scoreboard dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .issue_valid  (issue_valid),
    .issue_ready  (issue_ready),
    .u_from_gd    (u_from_gd),
    .u_to_gd      (u_to_gd),
    .u_from_gs    (u_from_gs),
    .u_from_gt    (u_from_gt),
    .u_from_ef    (u_from_ef),
    .u_to_ef      (u_to_ef),
    .u_d          (u_d),
    .u_s          (u_s),
    .u_t          (u_t),
    .wb_gd_valid  (wb_gd_valid),
    .wb_gd_idx    (wb_gd_idx),
    .wb_ef_valid  (wb_ef_valid),
    .gpr_busy     (gpr_busy),
    .ef_busy      (ef_busy),
    .sb_error     (sb_error),
    .stall_cycles (stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_op();
    issue_valid = 1'b0;
    u_from_gd   = 1'b0;
    u_to_gd     = 1'b0;
    u_from_gs   = 1'b0;
    u_from_gt   = 1'b0;
    u_from_ef   = 1'b0;
    u_to_ef     = 1'b0;
    u_d         = '0;
    u_s         = '0;
    u_t         = '0;
  endtask

  task automatic clr_wb();
    wb_gd_valid = 1'b0;
    wb_gd_idx   = '0;
    wb_ef_valid = 1'b0;
  endtask

  task automatic movi(input logic [3:0] d);
    clr_op();
    issue_valid = 1'b1;
    u_to_gd     = 1'b1;
    u_d         = d;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    flush = 1'b0;
    clr_op();
    clr_wb();
    tick();
    tick();
    rst = 1'b0;
    #1;
    sb.push_back(32'h0);
    sb.push_back(32'h0);
    sb.push_back(32'h0);
    sb.push_back(32'h0);
    sb.push_back(32'h1);
    checks++; ex = sb.pop_front();
    if (32'(gpr_busy) !== ex) begin failures++; $display("FAIL rst_gpr_busy got=%0h exp=%0h", gpr_busy, ex); end
    checks++; ex = sb.pop_front();
    if (32'(ef_busy) !== ex) begin failures++; $display("FAIL rst_ef_busy got=%0h exp=%0h", ef_busy, ex); end
    checks++; ex = sb.pop_front();
    if (32'(sb_error) !== ex) begin failures++; $display("FAIL rst_sb_error got=%0h exp=%0h", sb_error, ex); end
    checks++; ex = sb.pop_front();
    if (stall_cycles !== ex) begin failures++; $display("FAIL rst_stall got=%0d exp=%0d", stall_cycles, ex); end
    checks++; ex = sb.pop_front();
    if (32'(issue_ready) !== ex) begin failures++; $display("FAIL rst_ready got=%0h exp=%0h", issue_ready, ex); end
  endtask

  task automatic test_raw();
    clr_op();
    issue_valid = 1'b1;
    u_to_gd = 1'b1; u_from_gs = 1'b1; u_from_gt = 1'b1;
    u_from_ef = 1'b1; u_to_ef = 1'b1;
    u_d = 4'd3; u_s = 4'd1; u_t = 4'd2;
    sb.push_back(32'h1);
    #1;
    checks++; ex = sb.pop_front();
    if (32'(issue_ready) !== ex) begin failures++; $display("FAIL add_ready got=%0h exp=%0h", issue_ready, ex); end
    tick();
    clr_op();
    issue_valid = 1'b1;
    u_to_gd = 1'b1; u_from_gt = 1'b1;
    u_d = 4'd5; u_t = 4'd3;
    sb.push_back(32'h0008);
    sb.push_back(32'h1);
    sb.push_back(32'h0);
    #1;
    checks++; ex = sb.pop_front();
    if (32'(gpr_busy) !== ex) begin failures++; $display("FAIL add_busy got=%0h exp=%0h", gpr_busy, ex); end
    checks++; ex = sb.pop_front();
    if (32'(ef_busy) !== ex) begin failures++; $display("FAIL add_ef_busy got=%0h exp=%0h", ef_busy, ex); end
    checks++; ex = sb.pop_front();
    if (32'(issue_ready) !== ex) begin failures++; $display("FAIL mov_held got=%0h exp=%0h", issue_ready, ex); end
    for (int i = 0; i < 3; i++) begin
      tick();
      exp_stall++;
    end
    wb_gd_valid = 1'b1;
    wb_gd_idx = 4'd3;
    sb.push_back(32'h0);
    #1;
    checks++; ex = sb.pop_front();
    if (32'(issue_ready) !== ex) begin failures++; $display("FAIL wb_no_bypass got=%0h exp=%0h", issue_ready, ex); end
    tick();
    exp_stall++;
    clr_wb();
    sb.push_back(32'h1);
    sb.push_back(32'h0);
    sb.push_back(32'(exp_stall));
    #1;
    checks++; ex = sb.pop_front();
    if (32'(issue_ready) !== ex) begin failures++; $display("FAIL mov_release got=%0h exp=%0h", issue_ready, ex); end
    checks++; ex = sb.pop_front();
    if (32'(gpr_busy[3]) !== ex) begin failures++; $display("FAIL bit3_clear got=%0h exp=%0h", gpr_busy[3], ex); end
    checks++; ex = sb.pop_front();
    if (stall_cycles !== ex) begin failures++; $display("FAIL raw_stall got=%0d exp=%0d", stall_cycles, ex); end
    tick();
    clr_op();
    sb.push_back(32'h0020);
    #1;
    checks++; ex = sb.pop_front();
    if (32'(gpr_busy) !== ex) begin failures++; $display("FAIL mov_busy got=%0h exp=%0h", gpr_busy, ex); end
    wb_gd_valid = 1'b1;
    wb_gd_idx = 4'd5;
    wb_ef_valid = 1'b1;
    tick();
    clr_wb();
    sb.push_back(32'h0);
    sb.push_back(32'h0);
    #1;
    checks++; ex = sb.pop_front();
    if (32'(gpr_busy) !== ex) begin failures++; $display("FAIL raw_drain got=%0h exp=%0h", gpr_busy, ex); end
    checks++; ex = sb.pop_front();
    if (32'(ef_busy) !== ex) begin failures++; $display("FAIL ef_drain got=%0h exp=%0h", ef_busy, ex); end
  endtask

  task automatic test_sat();
    for (int i = 0; i < 3; i++) begin
      movi(4'd7);
      sb.push_back(32'h1);
      #1;
      checks++; ex = sb.pop_front();
      if (32'(issue_ready) !== ex) begin failures++; $display("FAIL movi7_ready%0d got=%0h exp=%0h", i, issue_ready, ex); end
      tick();
    end
    sb.push_back(32'h0080);
    sb.push_back(32'h0);
    #1;
    checks++; ex = sb.pop_front();
    if (32'(gpr_busy) !== ex) begin failures++; $display("FAIL sat_busy got=%0h exp=%0h", gpr_busy, ex); end
    checks++; ex = sb.pop_front();
    if (32'(issue_ready) !== ex) begin failures++; $display("FAIL sat_held got=%0h exp=%0h", issue_ready, ex); end
    tick();
    exp_stall++;
    wb_gd_valid = 1'b1;
    wb_gd_idx = 4'd7;
    tick();
    exp_stall++;
    clr_wb();
    sb.push_back(32'h1);
    #1;
    checks++; ex = sb.pop_front();
    if (32'(issue_ready) !== ex) begin failures++; $display("FAIL sat_release got=%0h exp=%0h", issue_ready, ex); end
    tick();
    sb.push_back(32'h0);
    #1;
    checks++; ex = sb.pop_front();
    if (32'(issue_ready) !== ex) begin failures++; $display("FAIL sat_again got=%0h exp=%0h", issue_ready, ex); end
    clr_op();
    wb_gd_valid = 1'b1;
    wb_gd_idx = 4'd7;
    tick();
    tick();
    sb.push_back(32'h0080);
    #1;
    checks++; ex = sb.pop_front();
    if (32'(gpr_busy) !== ex) begin failures++; $display("FAIL sat_count3 got=%0h exp=%0h", gpr_busy, ex); end
    tick();
    clr_wb();
    sb.push_back(32'h0);
    sb.push_back(32'h0);
    sb.push_back(32'(exp_stall));
    #1;
    checks++; ex = sb.pop_front();
    if (32'(gpr_busy) !== ex) begin failures++; $display("FAIL sat_drain got=%0h exp=%0h", gpr_busy, ex); end
    checks++; ex = sb.pop_front();
    if (32'(sb_error) !== ex) begin failures++; $display("FAIL sat_noerr got=%0h exp=%0h", sb_error, ex); end
    checks++; ex = sb.pop_front();
    if (stall_cycles !== ex) begin failures++; $display("FAIL sat_stall got=%0d exp=%0d", stall_cycles, ex); end
  endtask

  task automatic test_same_cycle();
    movi(4'd4);
    tick();
    wb_gd_valid = 1'b1;
    wb_gd_idx = 4'd4;
    sb.push_back(32'h1);
    #1;
    checks++; ex = sb.pop_front();
    if (32'(issue_ready) !== ex) begin failures++; $display("FAIL same_ready got=%0h exp=%0h", issue_ready, ex); end
    tick();
    clr_op();
    clr_wb();
    sb.push_back(32'h0010);
    sb.push_back(32'h0);
    #1;
    checks++; ex = sb.pop_front();
    if (32'(gpr_busy) !== ex) begin failures++; $display("FAIL same_busy got=%0h exp=%0h", gpr_busy, ex); end
    checks++; ex = sb.pop_front();
    if (32'(sb_error) !== ex) begin failures++; $display("FAIL same_noerr got=%0h exp=%0h", sb_error, ex); end
    wb_gd_valid = 1'b1;
    wb_gd_idx = 4'd4;
    tick();
    clr_wb();
    sb.push_back(32'h0);
    sb.push_back(32'h0);
    #1;
    checks++; ex = sb.pop_front();
    if (32'(gpr_busy) !== ex) begin failures++; $display("FAIL same_count1 got=%0h exp=%0h", gpr_busy, ex); end
    checks++; ex = sb.pop_front();
    if (32'(sb_error) !== ex) begin failures++; $display("FAIL same_drain_err got=%0h exp=%0h", sb_error, ex); end
  endtask

  task automatic test_flush();
    movi(4'd2);
    tick();
    tick();
    clr_op();
    issue_valid = 1'b1;
    u_to_ef = 1'b1;
    tick();
    movi(4'd6);
    flush = 1'b1;
    wb_gd_valid = 1'b1;
    wb_gd_idx = 4'd11;
    sb.push_back(32'h0004);
    sb.push_back(32'h1);
    sb.push_back(32'h0);
    #1;
    checks++; ex = sb.pop_front();
    if (32'(gpr_busy) !== ex) begin failures++; $display("FAIL pre_flush_busy got=%0h exp=%0h", gpr_busy, ex); end
    checks++; ex = sb.pop_front();
    if (32'(ef_busy) !== ex) begin failures++; $display("FAIL pre_flush_ef got=%0h exp=%0h", ef_busy, ex); end
    checks++; ex = sb.pop_front();
    if (32'(issue_ready) !== ex) begin failures++; $display("FAIL flush_ready got=%0h exp=%0h", issue_ready, ex); end
    tick();
    exp_stall++;
    flush = 1'b0;
    clr_op();
    clr_wb();
    sb.push_back(32'h0);
    sb.push_back(32'h0);
    sb.push_back(32'h0);
    sb.push_back(32'(exp_stall));
    #1;
    checks++; ex = sb.pop_front();
    if (32'(gpr_busy) !== ex) begin failures++; $display("FAIL flush_busy got=%0h exp=%0h", gpr_busy, ex); end
    checks++; ex = sb.pop_front();
    if (32'(ef_busy) !== ex) begin failures++; $display("FAIL flush_ef got=%0h exp=%0h", ef_busy, ex); end
    checks++; ex = sb.pop_front();
    if (32'(sb_error) !== ex) begin failures++; $display("FAIL flush_wb_err got=%0h exp=%0h", sb_error, ex); end
    checks++; ex = sb.pop_front();
    if (stall_cycles !== ex) begin failures++; $display("FAIL flush_stall got=%0d exp=%0d", stall_cycles, ex); end
  endtask

  task automatic test_underflow();
    wb_gd_valid = 1'b1;
    wb_gd_idx = 4'd9;
    tick();
    clr_wb();
    sb.push_back(32'h1);
    sb.push_back(32'h0);
    #1;
    checks++; ex = sb.pop_front();
    if (32'(sb_error) !== ex) begin failures++; $display("FAIL uf_error got=%0h exp=%0h", sb_error, ex); end
    checks++; ex = sb.pop_front();
    if (32'(gpr_busy) !== ex) begin failures++; $display("FAIL uf_busy got=%0h exp=%0h", gpr_busy, ex); end
    tick();
    movi(4'd9);
    sb.push_back(32'h1);
    sb.push_back(32'h1);
    #1;
    checks++; ex = sb.pop_front();
    if (32'(sb_error) !== ex) begin failures++; $display("FAIL uf_sticky got=%0h exp=%0h", sb_error, ex); end
    checks++; ex = sb.pop_front();
    if (32'(issue_ready) !== ex) begin failures++; $display("FAIL uf_nowrap got=%0h exp=%0h", issue_ready, ex); end
    tick();
    clr_op();
    wb_gd_valid = 1'b1;
    wb_gd_idx = 4'd9;
    tick();
    clr_wb();
    sb.push_back(32'h0);
    #1;
    checks++; ex = sb.pop_front();
    if (32'(gpr_busy) !== ex) begin failures++; $display("FAIL uf_drain got=%0h exp=%0h", gpr_busy, ex); end
  endtask

  task automatic test_rst_mid_stall();
    movi(4'd1);
    tick();
    clr_op();
    issue_valid = 1'b1;
    u_from_gs = 1'b1;
    u_s = 4'd1;
    tick();
    exp_stall++;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sb.push_back(32'h0);
    sb.push_back(32'h0);
    sb.push_back(32'h0);
    sb.push_back(32'h0);
    sb.push_back(32'h1);
    #1;
    checks++; ex = sb.pop_front();
    if (32'(gpr_busy) !== ex) begin failures++; $display("FAIL rst2_busy got=%0h exp=%0h", gpr_busy, ex); end
    checks++; ex = sb.pop_front();
    if (32'(ef_busy) !== ex) begin failures++; $display("FAIL rst2_ef got=%0h exp=%0h", ef_busy, ex); end
    checks++; ex = sb.pop_front();
    if (32'(sb_error) !== ex) begin failures++; $display("FAIL rst2_err got=%0h exp=%0h", sb_error, ex); end
    checks++; ex = sb.pop_front();
    if (stall_cycles !== ex) begin failures++; $display("FAIL rst2_stall got=%0d exp=%0d", stall_cycles, ex); end
    checks++; ex = sb.pop_front();
    if (32'(issue_ready) !== ex) begin failures++; $display("FAIL rst2_ready got=%0h exp=%0h", issue_ready, ex); end
    clr_op();
    tick();
  endtask

  initial begin
    checks = 0;
    failures = 0;
    exp_stall = 0;
    test_reset();
    test_raw();
    test_sat();
    test_same_cycle();
    test_flush();
    test_underflow();
    test_rst_mid_stall();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
